seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider.sv | 159 +++++++++++++++
 tb/tb_seq_divider.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Sequential signed divider: 16-bit dividend / 8-bit divisor, restoring algorithm.
// One quotient bit per cycle over 16 CALC cycles, sign fix-up in FIX.
// Optional Error output is compiled in when SEQDIV_ERR_EN is defined.
module seq_divider (
    input  logic        clk,
    input  logic        Resetn,
    input  logic        Start,
    input  logic [15:0] Dividend,
    input  logic [7:0]  Divisor,
    output logic        Finish,
    output logic [7:0]  Quotient,
    output logic [7:0]  Remainder
`ifdef SEQDIV_ERR_EN
    ,
    output logic        Error
`endif
);

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        w_accept;

    logic [3:0]  r_count;
    logic [15:0] r_work;      // dividend magnitude shifts out, quotient bits shift in
    logic [8:0]  r_dvs;       // divisor magnitude, 9 bits so -128 becomes 128
    logic [8:0]  r_rem;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_zero;
    logic [7:0]  r_dvd_lo;
    logic        r_finish;
    logic [7:0]  r_quot;
    logic [7:0]  r_remd;

    logic [15:0] w_abs_dvd;
    logic [8:0]  w_abs_dvs;
    logic [9:0]  w_shift;
    logic [9:0]  w_trial;
    logic [16:0] w_q_signed;
    logic [7:0]  w_r_signed;

    assign w_abs_dvd  = Dividend[15] ? (16'd0 - Dividend) : Dividend;
    assign w_abs_dvs  = Divisor[7] ? (9'd0 - {Divisor[7], Divisor}) : {1'b0, Divisor};
    assign w_shift    = {r_rem, r_work[15]};
    assign w_trial    = w_shift - {1'b0, r_dvs};
    assign w_q_signed = r_neg_q ? (17'd0 - {1'b0, r_work}) : {1'b0, r_work};
    assign w_r_signed = r_neg_r ? (8'd0 - r_rem[7:0]) : r_rem[7:0];

`ifdef SEQDIV_ERR_EN
    logic r_error;
    logic w_ovf;

    // Signed quotient outside -128..127
    assign w_ovf = r_neg_q ? (r_work > 16'd128) : (r_work > 16'd127);
    assign Error = r_error;

    // Error flag: set in FIX on overflow or zero divisor, cleared on accept
    always_ff @(posedge clk or posedge Resetn) begin
        if (Resetn) begin
            r_error <= 1'b0;
        end else if (w_accept) begin
            r_error <= 1'b0;
        end else if (r_state == StFix) begin
            r_error <= r_zero | w_ovf;
        end
    end
`endif

    assign Finish    = r_finish;
    assign Quotient  = r_quot;
    assign Remainder = r_remd;

    // State register
    always_ff @(posedge clk or posedge Resetn) begin
        if (Resetn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; Start is only looked at in IDLE
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            StIdle: begin
                if (Start) begin
                    w_accept     = 1'b1;
                    w_state_next = (Divisor == 8'd0) ? StFix : StCalc;
                end
            end
            StCalc: begin
                if (r_count == 4'd15) begin
                    w_state_next = StFix;
                end
            end
            StFix:   w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Datapath: capture on accept, one restoring step per CALC cycle, sign fix in FIX
    always_ff @(posedge clk or posedge Resetn) begin
        if (Resetn) begin
            r_count  <= 4'd0;
            r_work   <= 16'd0;
            r_dvs    <= 9'd0;
            r_rem    <= 9'd0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_zero   <= 1'b0;
            r_dvd_lo <= 8'd0;
            r_finish <= 1'b0;
            r_quot   <= 8'd0;
            r_remd   <= 8'd0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_count  <= 4'd0;
                        r_work   <= w_abs_dvd;
                        r_dvs    <= w_abs_dvs;
                        r_rem    <= 9'd0;
                        r_neg_q  <= Dividend[15] ^ Divisor[7];
                        r_neg_r  <= Dividend[15];
                        r_zero   <= (Divisor == 8'd0);
                        r_dvd_lo <= Dividend[7:0];
                        r_finish <= 1'b0;
                    end
                end
                StCalc: begin
                    if (!w_trial[9]) begin
                        r_rem  <= w_trial[8:0];
                        r_work <= {r_work[14:0], 1'b1};
                    end else begin
                        r_rem  <= w_shift[8:0];
                        r_work <= {r_work[14:0], 1'b0};
                    end
                    r_count <= r_count + 4'd1;
                end
                StFix: begin
                    r_finish <= 1'b1;
                    if (r_zero) begin
                        r_quot <= 8'h00;
                        r_remd <= r_dvd_lo;
                    end else begin
                        r_quot <= w_q_signed[7:0];
                        r_remd <= w_r_signed;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes expected results, a monitor
// pops and compares on each Finish rise. Latency is counted including the accept edge.
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        Resetn;
    logic        Start;
    logic [15:0] Dividend;
    logic [7:0]  Divisor;
    logic        Finish;
    logic [7:0]  Quotient;
    logic [7:0]  Remainder;
`ifdef SEQDIV_ERR_EN
    logic        Error;
`endif

    seq_divider dut (
        .clk       (clk),
        .Resetn    (Resetn),
        .Start     (Start),
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .Finish    (Finish),
        .Quotient  (Quotient),
        .Remainder (Remainder)
`ifdef SEQDIV_ERR_EN
        ,
        .Error     (Error)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       err;
        int         lat;       // edges from accept to Finish, counting the accept edge
        int         acc_cyc;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;
    logic prev_fin = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare each completed result with the head of the scoreboard
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (Finish && !prev_fin) begin
            if (sb.size() == 0) begin
                chk("unexpected_finish", 1, 0);
            end else begin
                e = sb.pop_front();
                chk({e.name, "_quotient"}, int'(Quotient), int'(e.q));
                chk({e.name, "_remainder"}, int'(Remainder), int'(e.r));
                chk({e.name, "_latency"}, cyc - e.acc_cyc + 1, e.lat);
`ifdef SEQDIV_ERR_EN
                chk({e.name, "_error"}, int'(Error), int'(e.err));
`endif
            end
        end
        prev_fin = Finish;
    end

    // Called at a negedge: the next posedge is the accepting edge
    task automatic push(input string name, input logic [15:0] dvd, input logic [7:0] dvs,
                        input logic [7:0] q, input logic [7:0] r, input logic err);
        exp_t e;
        Dividend  = dvd;
        Divisor   = dvs;
        Start     = 1'b1;
        e.name    = name;
        e.q       = q;
        e.r       = r;
        e.err     = err;
        e.lat     = (dvs == 8'd0) ? 2 : 18;
        e.acc_cyc = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic wait_finish(input string name);
        int n;
        n = 0;
        while (Finish !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (Finish !== 1'b1) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic run_op(input string name, input logic [15:0] dvd, input logic [7:0] dvs,
                          input logic [7:0] q, input logic [7:0] r, input logic err);
        @(negedge clk);
        push(name, dvd, dvs, q, r, err);
        @(negedge clk);
        Start = 1'b0;
        chk({name, "_finish_drop"}, int'(Finish), 0);
        wait_finish(name);
        repeat (3) @(negedge clk);
        chk({name, "_hold_q"}, int'(Quotient), int'(q));
        chk({name, "_hold_r"}, int'(Remainder), int'(r));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        Resetn   = 1'b1;
        Start    = 1'b0;
        Dividend = 16'd0;
        Divisor  = 8'd0;
        repeat (3) @(negedge clk);
        chk("reset_finish", int'(Finish), 0);
        chk("reset_quotient", int'(Quotient), 0);
        chk("reset_remainder", int'(Remainder), 0);
`ifdef SEQDIV_ERR_EN
        chk("reset_error", int'(Error), 0);
`endif
        Resetn = 1'b0;

        run_op("d1000_10",   16'd1000,  8'd10,   8'h64, 8'h00, 1'b0);
        run_op("dm100_7",    16'hFF9C,  8'd7,    8'hF2, 8'hFE, 1'b0);
        run_op("d100_m7",    16'd100,   8'hF9,   8'hF2, 8'h02, 1'b0);
        run_op("d1000_3",    16'd1000,  8'd3,    8'h4D, 8'h01, 1'b1);
        run_op("dm1280_10",  16'hFB00,  8'd10,   8'h80, 8'h00, 1'b0);
        run_op("dmin_m128",  16'h8000,  8'h80,   8'h00, 8'h00, 1'b1);
        run_op("zero_div",   16'h1234,  8'h00,   8'h00, 8'h34, 1'b1);
        run_op("d127_1",     16'd127,   8'd1,    8'h7F, 8'h00, 1'b0);
        run_op("dm128_m1",   16'hFF80,  8'hFF,   8'h80, 8'h00, 1'b1);
        run_op("d7_m128",    16'd7,     8'h80,   8'h00, 8'h07, 1'b0);
        run_op("dm7_2",      16'hFFF9,  8'd2,    8'hFD, 8'hFF, 1'b0);
        run_op("dmin_1",     16'h8000,  8'd1,    8'h00, 8'h00, 1'b1);

        // Start toggling during CALC must not disturb result or timing
        @(negedge clk);
        push("toggle", 16'd1000, 8'd10, 8'h64, 8'h00, 1'b0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            Start = (i % 2 == 1);
            Dividend = 16'd5;
        end
        Start = 1'b0;
        wait_finish("toggle");
        @(negedge clk);

        // Reset in the middle of CALC aborts the operation
        @(negedge clk);
        push("abort", 16'd5000, 8'd7, 8'h00, 8'h00, 1'b0);
        @(negedge clk);
        Start = 1'b0;
        repeat (8) @(negedge clk);
        Resetn = 1'b1;
        void'(sb.pop_back());
        #1;
        chk("abort_finish", int'(Finish), 0);
        chk("abort_quotient", int'(Quotient), 0);
        chk("abort_remainder", int'(Remainder), 0);
        @(negedge clk);
        Resetn = 1'b0;
        repeat (30) @(negedge clk);
        chk("abort_no_finish", int'(Finish), 0);

        // Back-to-back with Start held high
        @(negedge clk);
        push("b2b_0", 16'd100, 8'hF9, 8'hF2, 8'h02, 1'b0);
        @(negedge clk);
        Dividend = 16'hFF9C;
        Divisor  = 8'd7;
        wait_finish("b2b_0");
        push("b2b_1", 16'hFF9C, 8'd7, 8'hF2, 8'hFE, 1'b0);
        @(negedge clk);
        chk("b2b_1_finish_pulse", int'(Finish), 0);
        wait_finish("b2b_1");
        push("b2b_2", 16'd1000, 8'd10, 8'h64, 8'h00, 1'b0);
        @(negedge clk);
        chk("b2b_2_finish_pulse", int'(Finish), 0);
        Start = 1'b0;
        wait_finish("b2b_2");
        repeat (4) @(negedge clk);
        chk("b2b_2_stable", int'(Finish), 1);

        chk("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
